// File: rtl/aes_pkg.sv
// Shared AES constants: block width, forward/inverse S-box tables and the
// substitution FSM state type.
package aes_pkg;

  localparam int BLOCO_W = 128;

  typedef enum logic [1:0] {OCIOSO, PROCESSA, PRONTO} estado_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/caixa_s.sv
// Single-byte S-box: forward table when modo_i=0, inverse table when modo_i=1.
module caixa_s
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic       modo_i,
  output logic [7:0] byte_o
);

  always_comb begin
    byte_o = modo_i ? INV_SBOX[byte_i] : SBOX[byte_i];
  end

endmodule

// File: rtl/substitui_bytes_iterativo.sv
// Iterative (Inv)SubBytes: substitutes LANES bytes per cycle of a latched
// 128-bit state, then holds the result until the consumer takes it.
module substitui_bytes_iterativo
  import aes_pkg::*;
#(
  parameter int LANES     = 4,
  parameter bit SAIDA_REG = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCO_W-1:0] bloco,
  input  logic               modo,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCO_W-1:0] saida
);

  localparam int N     = 16 / LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (LANES < 1 || LANES > 16 || (16 % LANES) != 0) begin : g_lanes_invalida
    $error("substitui_bytes_iterativo: LANES=%0d must divide 16", LANES);
  end

  estado_t            estado_q, estado_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCO_W-1:0] trab_q, trab_d;
  logic               modo_q, modo_d;
  logic [7:0]         lane_in  [LANES];
  logic [7:0]         lane_out [LANES];

  // Lane j always looks at byte LANES*cnt+j of the working register.
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_in[j] = trab_q[8*(int'(cnt_q)*LANES + j) +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    caixa_s u_caixa (
      .byte_i (lane_in[g]),
      .modo_i (modo_q),
      .byte_o (lane_out[g])
    );
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    trab_d   = trab_q;
    modo_d   = modo_q;
    case (estado_q)
      OCIOSO: begin
        if (in_valid) begin
          trab_d   = bloco;
          modo_d   = modo;
          cnt_d    = '0;
          estado_d = PROCESSA;
        end
      end
      PROCESSA: begin
        for (int j = 0; j < LANES; j++) begin
          trab_d[8*(int'(cnt_q)*LANES + j) +: 8] = lane_out[j];
        end
        if (cnt_q == CNT_W'(N - 1)) begin
          cnt_d    = '0;
          estado_d = PRONTO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRONTO: begin
        if (out_ready) begin
          estado_d = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      cnt_q    <= '0;
      trab_q   <= '0;
      modo_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      trab_q   <= trab_d;
      modo_q   <= modo_d;
    end
  end

  // The output register only loads on the edge that completes the last group.
  if (SAIDA_REG) begin : g_saida_reg
    logic [BLOCO_W-1:0] saida_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        saida_q <= '0;
      end else if (estado_q == PROCESSA && estado_d == PRONTO) begin
        saida_q <= trab_d;
      end
    end
    assign saida = saida_q;
  end else begin : g_saida_direta
    assign saida = trab_q;
  end

  assign in_ready  = (estado_q == OCIOSO);
  assign out_valid = (estado_q == PRONTO);

endmodule

// File: doc/substitui_bytes_iterativo.md
SUBSTITUI_BYTES_ITERATIVO -- requirements
Module: substitui_bytes_iterativo

Interface
REQ-001 Parameter LANES, default 4: bytes substituted per clock; legal values 1, 2, 4, 8, 16.
REQ-002 Parameter SAIDA_REG, default 1: 1 = saida driven from a register; 0 = saida driven from the working register, with the same timing.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  bloco/modo valid this cycle.
REQ-006 in_ready  output  1  block can accept a new bloco.
REQ-007 bloco  input  128  state to substitute; byte i = bloco[8i+7:8i].
REQ-008 modo  input  1  0 = forward S-box (SubBytes), 1 = inverse S-box (InvSubBytes).
REQ-009 out_valid  output  1  saida holds a completed result.
REQ-010 out_ready  input  1  consumer accepts saida.
REQ-011 saida  output  128  substituted state; byte i = S(bloco byte i) or S^-1(bloco byte i).

Function
REQ-012 The block SHALL use the complete 256-entry FIPS-197 forward and inverse tables, with every index 0x00..0xFF defined.
REQ-013 Let N = 16/LANES; the block SHALL implement states OCIOSO, PROCESSA and PRONTO.
REQ-014 In OCIOSO, in_ready SHALL be 1; in PROCESSA and PRONTO, in_ready SHALL be 0.
REQ-015 On a cycle with in_valid=1 in OCIOSO, the block SHALL latch bloco and modo, clear the byte-group counter cnt to 0, and go to PROCESSA.
REQ-016 In PROCESSA, each cycle SHALL replace bytes LANES*cnt .. LANES*cnt+LANES-1 of the working register with their table lookups, then increment cnt.
REQ-017 When cnt = N-1 in PROCESSA, the block SHALL go to PRONTO on that edge.
REQ-018 Latency SHALL be exactly N cycles from the accept edge to the first cycle with out_valid=1; N=1 when LANES=16.
REQ-019 In PRONTO, out_valid SHALL be 1 and saida SHALL stay stable until out_ready=1, after which the block SHALL return to OCIOSO on that edge.
REQ-020 The block SHALL NOT accept input in the cycle it leaves PRONTO; back-to-back throughput is one block per N+2 cycles.
REQ-021 saida SHALL change only on entry to PRONTO; changes to bloco, modo or in_valid after the accept edge SHALL have no effect on the result in flight.
REQ-022 If out_ready=1 while out_valid=0, or in_valid=1 while in_ready=0, the block SHALL ignore it.
REQ-023 cnt SHALL be ceil(log2(N)) bits, minimum 1 bit, and SHALL never exceed N-1.
REQ-024 A LANES value that does not divide 16 SHALL cause an elaboration-time error.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL enter OCIOSO, clear cnt, the working register and saida to 0, set out_valid=0, and set in_ready=1 from the next cycle.
REQ-026 Reset asserted in PROCESSA or PRONTO SHALL discard the block in flight; no out_valid pulse SHALL follow.
REQ-027 in_valid=1 during a reset cycle SHALL NOT be accepted.

Structure
REQ-028 Package aes_pkg SHALL hold the BLOCO_W=128 constant, the SBOX and INV_SBOX 256x8 constant tables, and the state enum type.
REQ-029 Sub-module caixa_s SHALL be a combinational 8-bit lookup with a modo select, instantiated LANES times.

Verification
REQ-030 LANES=16, modo=0, bloco=0 -> out_valid after 1 cycle, saida = 0x63 in all 16 bytes.
REQ-031 LANES=4, modo=0, bloco=00102030405060708090a0b0c0d0e0f0 -> out_valid exactly 4 cycles after accept, saida = 63cab7040953d051cd60e0e7ba70e18c.
REQ-032 LANES=1, bloco bytes 0xA0..0xA3 plus 0x53, modo=0 -> e0, 32, 3a, 0a, ed; then feed saida back with modo=1 -> original bloco, 16-cycle latency.
REQ-033 out_ready held 0 for 5 cycles in PRONTO while bloco and in_valid toggle -> saida stable, in_ready=0, one result delivered.
REQ-034 rst pulsed at cnt=2, LANES=4 -> out_valid never asserts for that block; a new block accepted on the first cycle after reset completes correctly.
